// File: rtl/barrel_rotator_pipe_if.sv
// Handshake and data bundle between a word producer, the barrel rotator and a consumer.
// The out_zero signal exists only when BARREL_ZERO_FLAG_EN is defined.
interface barrel_rotator_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amount;
  logic             in_dir;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef BARREL_ZERO_FLAG_EN
  logic             out_zero;
`endif

  // Producer/consumer side: drives words in and accepts results.
  modport master (
    output in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
`ifdef BARREL_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_data
  );

  // Rotator side: accepts words and presents results.
  modport slave (
    input  in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
`ifdef BARREL_ZERO_FLAG_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/barrel_rotator_pipe.sv
// Pipelined barrel rotator/shifter with valid/ready on both sides.
// Stage k moves the word by 2^k when amount bit k is set; amount, direction and mode
// travel alongside the data. PIPELINE=1 registers every stage, PIPELINE=0 keeps the
// stages combinational behind a single output register.
// Optional feature macro: BARREL_ZERO_FLAG_EN adds a registered out_zero flag.
module barrel_rotator_pipe #(
  parameter int WIDTH    = 8,
  parameter int PIPELINE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrel_rotator_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amount;
    logic             dir;
    logic [1:0]       mode;
  } word_t;

  // Move a word by s positions; mode 01 logical, 10 arithmetic, 00/11 rotate.
  function automatic logic [WIDTH-1:0] stepWord(input logic [WIDTH-1:0] d, input int s,
                                                input logic dir, input logic [1:0] mode);
    logic [WIDTH-1:0] r;
    case (mode)
      2'b01:   r = dir ? (d << s) : (d >> s);
      2'b10:   r = dir ? (d << s) : WIDTH'($signed(d) >>> s);
      default: r = dir ? ((d << s) | (d >> (WIDTH - s))) : ((d >> s) | (d << (WIDTH - s)));
    endcase
    return r;
  endfunction

  // Data produced by stage k: moved by 2^k if amount bit k is set, else passed through.
  function automatic logic [WIDTH-1:0] stageData(input word_t w, input int k);
    if (w.amount[k]) return stepWord(w.data, 1 << k, w.dir, w.mode);
    return w.data;
  endfunction

  // Whole word (with its control) after stage k.
  function automatic word_t applyStage(input word_t w, input int k);
    word_t r;
    r      = w;
    r.data = stageData(w, k);
    return r;
  endfunction

  word_t            inWord;
  logic             adv;
  logic             outValid_d;
  logic [WIDTH-1:0] outData_d;
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;

  assign inWord = '{data: bus.in_data, amount: bus.in_amount, dir: bus.in_dir, mode: bus.in_mode};

  // The whole pipe moves together; it only holds when a result is waiting unconsumed.
  assign adv           = bus.out_ready | ~outValid_q;
  assign bus.in_ready  = adv;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;

  generate
    if (PIPELINE != 0 && SHW > 1) begin : g_pipe
      word_t midWord_q  [SHW-1];
      word_t midWord_d  [SHW-1];
      logic  midValid_q [SHW-1];

      // Next contents of every intermediate stage register.
      always_comb begin
        midWord_d[0] = applyStage(inWord, 0);
        for (int k = 1; k < SHW - 1; k++) begin
          midWord_d[k] = applyStage(midWord_q[k-1], k);
        end
      end

      // Intermediate stage registers; bubbles travel as valid=0 and leave data untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SHW - 1; k++) begin
            midValid_q[k] <= 1'b0;
            midWord_q[k]  <= '0;
          end
        end else if (adv) begin
          midValid_q[0] <= bus.in_valid;
          if (bus.in_valid) midWord_q[0] <= midWord_d[0];
          for (int k = 1; k < SHW - 1; k++) begin
            midValid_q[k] <= midValid_q[k-1];
            if (midValid_q[k-1]) midWord_q[k] <= midWord_d[k];
          end
        end
      end

      assign outValid_d = midValid_q[SHW-2];
      assign outData_d  = stageData(midWord_q[SHW-2], SHW - 1);
    end else begin : g_comb
      word_t chainWord;

      // All but the last stage chained combinationally from the input word.
      always_comb begin
        chainWord = inWord;
        for (int k = 0; k < SHW - 1; k++) begin
          chainWord = applyStage(chainWord, k);
        end
      end

      assign outValid_d = bus.in_valid;
      assign outData_d  = stageData(chainWord, SHW - 1);
    end
  endgenerate

  // Output register: the final stage result, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else if (adv) begin
      outValid_q <= outValid_d;
      if (outValid_d) outData_q <= outData_d;
    end
  end

`ifdef BARREL_ZERO_FLAG_EN
  logic outZero_q;

  // Zero flag registered together with the result so it always matches out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outZero_q <= 1'b0;
    end else if (adv && outValid_d) begin
      outZero_q <= (outData_d == '0);
    end
  end

  assign bus.out_zero = outZero_q;
`endif
endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Scoreboard bench for barrel_rotator_pipe (WIDTH=8). Expected results are hand-computed
// in the vector table; a driver pushes them on acceptance and a monitor pops on consumption.
// Define BARREL_ZERO_FLAG_EN to also check out_zero.
module tb_barrel_rotator_pipe;
  localparam int WIDTH = 8;
  parameter int PIPELINE = 1;
  localparam int LAT = (PIPELINE != 0) ? $clog2(WIDTH) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  barrel_rotator_pipe_if #(.WIDTH(WIDTH)) bus();

  barrel_rotator_pipe #(.WIDTH(WIDTH), .PIPELINE(PIPELINE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic       dir;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  vec_t vecs [16] = '{
    '{8'hB1, 3'd3, 1'b0, 2'd0, 8'h36},
    '{8'hB1, 3'd3, 1'b1, 2'd0, 8'h8D},
    '{8'hB1, 3'd0, 1'b0, 2'd0, 8'hB1},
    '{8'hB1, 3'd3, 1'b0, 2'd1, 8'h16},
    '{8'hB1, 3'd3, 1'b0, 2'd2, 8'hF6},
    '{8'hB1, 3'd3, 1'b1, 2'd1, 8'h88},
    '{8'hB1, 3'd3, 1'b1, 2'd2, 8'h88},
    '{8'hB1, 3'd3, 1'b0, 2'd3, 8'h36},
    '{8'h80, 3'd1, 1'b1, 2'd1, 8'h00},
    '{8'h80, 3'd1, 1'b1, 2'd0, 8'h01},
    '{8'h81, 3'd7, 1'b0, 2'd2, 8'hFF},
    '{8'h4C, 3'd7, 1'b0, 2'd2, 8'h00},
    '{8'hB1, 3'd7, 1'b1, 2'd0, 8'hD8},
    '{8'hF0, 3'd4, 1'b0, 2'd1, 8'h0F},
    '{8'h5A, 3'd0, 1'b1, 2'd2, 8'h5A},
    '{8'h01, 3'd7, 1'b1, 2'd1, 8'h80}
  };

  typedef struct {
    logic [7:0] data;
    int         acceptCyc;
    bit         checkLat;
    bit         checkGap;
  } exp_t;

  exp_t sbQ [$];
  exp_t monE;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lastPopCyc = -1;
  int   waited;

  // Cycle counter, bumped on every rising edge.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one word and wait (bounded) for it to be accepted; called just after a rising edge.
  task automatic applyStimulus(input vec_t v, input bit checkLat, input bit checkGap, output int nWait);
    exp_t e;
    bit   accepted;
    bus.in_valid  = 1'b1;
    bus.in_data   = v.d;
    bus.in_amount = v.a;
    bus.in_dir    = v.dir;
    bus.in_mode   = v.m;
    nWait    = 0;
    accepted = 0;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data      = v.e;
        e.acceptCyc = cyc;
        e.checkLat  = checkLat;
        e.checkGap  = checkGap;
        sbQ.push_back(e);
        accepted = 1;
      end else begin
        nWait++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_empty", sbQ.size(), 0);
  endtask

  // Monitor: every presented result must match the oldest outstanding word; pop on consume.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        monE = sbQ[0];
        checkOutput("out_data", bus.out_data, monE.data);
`ifdef BARREL_ZERO_FLAG_EN
        checkOutput("out_zero", bus.out_zero, (monE.data == 8'h00));
`endif
        if (bus.out_ready) begin
          if (monE.checkLat) checkOutput("latency", cyc - monE.acceptCyc, LAT);
          if (monE.checkGap) checkOutput("stream_gap", cyc - lastPopCyc, 1);
          lastPopCyc = cyc;
          void'(sbQ.pop_front());
        end
      end
    end
  end

  // Hard stop in case anything wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_dir    = 1'b0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b1;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_data", bus.out_data, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
`ifdef BARREL_ZERO_FLAG_EN
    checkOutput("reset_out_zero", bus.out_zero, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, with latency checked on each.
    $display("[TB] directed vectors");
    foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, 1'b0, waited);
    idle();
    drain();

    // Stream of 8 words: consecutive results and no back-pressure.
    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b1, (i != 0), waited);
      checkOutput("stream_in_ready", waited, 0);
    end
    idle();
    drain();

    // Consumer stall with the pipe full, then release.
    $display("[TB] stall");
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 8; i < 13; i++) applyStimulus(vecs[i], 1'b0, 1'b0, waited);
        idle();
      end
      begin
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          checkOutput("stall_in_ready", bus.in_ready, 0);
          checkOutput("stall_out_valid", bus.out_valid, 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three words in flight.
    $display("[TB] reset in flight");
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], 1'b0, 1'b0, waited);
    idle();
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("midreset_out_valid", bus.out_valid, 0);
    checkOutput("midreset_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_reset_out_valid", bus.out_valid, 0);
    end

    // One more word after reset to show the pipe is alive again.
    @(posedge clk);
    #1;
    applyStimulus(vecs[1], 1'b1, 1'b0, waited);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
